popcount_stream: RTL and testbench
==================================

POPCOUNT_STREAM -- requirements
Module: popcount_stream

Interface
REQ-001 Parameter DATA_W, default 1024: total input vector width in bits.
REQ-002 Parameter CHUNK_W, default 64: bits counted per RUN cycle; power of two, at least 2, must divide DATA_W.
REQ-003 Derived constants: NCHUNK = DATA_W/CHUNK_W; CNT_W = clog2(DATA_W+1), which is 11 at the defaults.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: in_data and thresh are valid.
REQ-007 Port in_ready, output, 1 bit: block can accept a vector.
REQ-008 Port in_data, input, DATA_W bits: vector whose 1-bits are counted.
REQ-009 Port thresh, input, CNT_W bits: compare threshold, captured with in_data.
REQ-010 Port out_valid, output, 1 bit: result available.
REQ-011 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 Port out_count, output, CNT_W bits: number of 1-bits in the accepted vector.
REQ-013 Port out_ge, output, 1 bit: asserted when out_count >= captured thresh.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 in IDLE only and 0 in RUN and DONE.
REQ-016 Accept occurs on a rising edge with IDLE and in_valid=1; at that edge: in_data goes to shift register sh, thresh to thr_q, accumulator cleared to 0, chunk counter to 0, state to RUN.
REQ-017 Each RUN edge: acc += popcount(sh[CHUNK_W-1:0]); sh shifts right by CHUNK_W; chunk counter increments.
REQ-018 At the RUN edge where chunk counter = NCHUNK-1, after the add, state SHALL go to DONE.
REQ-019 out_valid SHALL be 1 exactly when state is DONE; first high after the NCHUNK-th rising edge following the accept edge (16 cycles at defaults).
REQ-020 In DONE, out_count SHALL equal acc and out_ge SHALL equal (acc >= thr_q); both stable while out_valid=1 and out_ready=0.
REQ-021 A DONE edge with out_ready=1 SHALL return the block to IDLE; there is no accept on that same edge.
REQ-022 Throughput: one vector per NCHUNK+2 cycles maximum.
REQ-023 in_valid and in_data SHALL be ignored outside IDLE; changes to them during RUN do not affect the result.
REQ-024 Arithmetic: the chunk popcount is clog2(CHUNK_W+1) bits, zero-extended to CNT_W; acc never overflows because its maximum is DATA_W.
REQ-025 When NCHUNK = 1, RUN SHALL last exactly one cycle.
REQ-026 In IDLE and RUN, out_count and out_ge SHALL read 0.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, acc=0, chunk counter=0, thr_q=0, sh=0 from any state, including mid-RUN and mid-DONE; the pending result is discarded.
REQ-028 Output values after reset: in_ready=1, out_valid=0, out_count=0, out_ge=0.
REQ-029 rst SHALL take priority over accept and over the out_ready handshake on the same edge.

Structure
REQ-030 The shared package popcount_pkg SHALL hold the state enumeration (IDLE/RUN/DONE) and a constant clog2 width function.
REQ-031 Sub-module pop_chunk SHALL be one parametrised combinational adder-tree popcount of CHUNK_W bits, with output width clog2(CHUNK_W+1); it is instantiated once.
REQ-032 The parameter legality check (CHUNK_W divides DATA_W and is a power of two) SHALL be an elaboration-time assertion.

Verification (defaults DATA_W=1024, CHUNK_W=64)
REQ-033 All-zero vector, thresh=0 -> out_count=0, out_ge=1, out_valid rises 16 cycles after accept.
REQ-034 All-ones vector, thresh=1025 -> out_count=1024, out_ge=0; check no overflow of the 11-bit count.
REQ-035 Vector 0x...0001 with bit 1023 also set, thresh=2 -> out_count=2, out_ge=1; proves the first and last chunks are counted.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_count and out_ge stable; in_ready=0 throughout; pulse out_ready -> IDLE on the next edge.
REQ-037 Assert rst at the 8th RUN cycle -> next cycle in IDLE, outputs 0, in_ready=1; next vector (512 ones) -> out_count=512.
REQ-038 200 random vectors back-to-back with random out_ready -> every out_count matches the reference count; rebuild with CHUNK_W=1024 and confirm the 1-cycle RUN.

Source files
------------

// File: rtl/popcount_stream_pkg.sv
// popcount_pkg: shared definitions for the popcount_stream block.
//   state_t : controller state encoding (IDLE / RUN / DONE), also exported
//             on the top-level debug port.
//   clog2() : constant ceil(log2(v)) used to size counters and ports.
package popcount_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= v. clog2(1) = 0, clog2(1025) = 11.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/popcount_stream_if.sv
// popcount_stream_if: input and result channels of popcount_stream.
//   in_valid/in_ready/in_data/thresh      : vector + threshold channel
//   out_valid/out_ready/out_count/out_ge  : result channel
// Handshake: a channel transfers on a rising edge where valid and ready are
// both 1. The producer holds payload stable while valid=1 and ready=0; ready
// may depend on state only, never combinationally on valid.
// Modports: slave = popcount_stream side, master = producer/consumer side.
interface popcount_stream_if #(
    parameter int DATA_W = 1024,
    parameter int CNT_W  = 11
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CNT_W-1:0]  thresh;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_ge;

    modport master (
        output in_valid, in_data, thresh, out_ready,
        input  in_ready, out_valid, out_count, out_ge
    );

    modport slave (
        input  in_valid, in_data, thresh, out_ready,
        output in_ready, out_valid, out_count, out_ge
    );

endinterface

// File: rtl/popcount_stream_pop_chunk.sv
// pop_chunk: combinational popcount of one CHUNK_W-bit slice.
//   i_bits  : CHUNK_W bits to count
//   o_count : number of 1-bits, clog2(CHUNK_W+1) bits wide
// Built as a balanced binary adder tree in heap order: node n has children
// 2n and 2n+1, leaves sit at CHUNK_W..2*CHUNK_W-1, the root is node 1.
// CHUNK_W must be a power of two so the tree is complete.
module pop_chunk
    import popcount_pkg::*;
#(
    parameter int CHUNK_W = 64,
    parameter int OUT_W   = clog2(CHUNK_W + 1)
) (
    input  logic [CHUNK_W-1:0] i_bits,
    output logic [OUT_W-1:0]   o_count
);

    logic [OUT_W-1:0] w_node [1:2*CHUNK_W-1];

    genvar k;
    generate
        for (k = 0; k < CHUNK_W; k++) begin : g_leaf
            assign w_node[CHUNK_W + k] = OUT_W'(i_bits[k]);
        end
        // Every partial sum fits in OUT_W because the root bound is CHUNK_W.
        for (k = 1; k < CHUNK_W; k++) begin : g_node
            assign w_node[k] = w_node[2*k] + w_node[2*k + 1];
        end
    endgenerate

    assign o_count = w_node[1];

endmodule

// File: rtl/popcount_stream.sv
// popcount_stream: counts the 1-bits of a DATA_W-bit vector, CHUNK_W bits
// per cycle, and compares the total against a captured threshold.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : popcount_stream_if.slave (vector in, count/compare out)
//   o_state   : current controller state, for debug and checkers
// A vector is accepted in IDLE, walked through NCHUNK RUN cycles, then held
// in DONE until the consumer takes it.
module popcount_stream
    import popcount_pkg::*;
#(
    parameter int DATA_W  = 1024,
    parameter int CHUNK_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    popcount_stream_if.slave    bus,
    output state_t              o_state
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = clog2(DATA_W + 1);
    localparam int PC_W   = clog2(CHUNK_W + 1);
    // Keep the chunk counter at least one bit wide for the NCHUNK=1 build.
    localparam int CC_W   = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

    generate
        if (CHUNK_W < 2 || (CHUNK_W & (CHUNK_W - 1)) != 0 || (DATA_W % CHUNK_W) != 0) begin : g_bad_params
            $error("popcount_stream: CHUNK_W must be a power of two >= 2 dividing DATA_W");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [DATA_W-1:0]  r_sh;
    logic [CNT_W-1:0]   r_thr;
    logic [CNT_W-1:0]   r_acc;
    logic [CC_W-1:0]    r_chunk;
    logic [PC_W-1:0]    w_pc;
    logic               w_last;

    pop_chunk #(
        .CHUNK_W (CHUNK_W),
        .OUT_W   (PC_W)
    ) u_pop_chunk (
        .i_bits  (r_sh[CHUNK_W-1:0]),
        .o_count (w_pc)
    );

    assign w_last = (r_chunk == CC_W'(NCHUNK - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_next = ST_RUN;
            ST_RUN:  if (w_last)        w_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sh    <= '0;
            r_thr   <= '0;
            r_acc   <= '0;
            r_chunk <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_sh    <= bus.in_data;
                        r_thr   <= bus.thresh;
                        r_acc   <= '0;
                        r_chunk <= '0;
                    end
                end
                ST_RUN: begin
                    // Accumulator cannot overflow: its maximum is DATA_W.
                    r_acc   <= r_acc + CNT_W'(w_pc);
                    r_sh    <= r_sh >> CHUNK_W;
                    r_chunk <= r_chunk + CC_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result fields read zero outside DONE so a consumer sees no stale data.
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_count = (r_state == ST_DONE) ? r_acc : '0;
    assign bus.out_ge    = (r_state == ST_DONE) && (r_acc >= r_thr);
    assign o_state       = r_state;

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream. Two instances share all inputs: u_dut0 at the
// default CHUNK_W=64 (16 RUN cycles) and u_dut1 at CHUNK_W=1024 (1 RUN
// cycle). They accept together and are released by the same out_ready pulse.
module tb_popcount_stream;
    import popcount_pkg::*;

    localparam int DATA_W = 1024;
    localparam int CNT_W  = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic [DATA_W-1:0] in_data;
    logic [CNT_W-1:0]  thresh;
    state_t            st0;
    state_t            st1;

    always #5 clk = ~clk;

    popcount_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_bus0 ();
    popcount_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_bus1 ();

    assign u_bus0.in_valid  = in_valid;
    assign u_bus0.in_data   = in_data;
    assign u_bus0.thresh    = thresh;
    assign u_bus0.out_ready = out_ready;
    assign u_bus1.in_valid  = in_valid;
    assign u_bus1.in_data   = in_data;
    assign u_bus1.thresh    = thresh;
    assign u_bus1.out_ready = out_ready;

    popcount_stream #(.DATA_W(DATA_W), .CHUNK_W(64)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .bus     (u_bus0),
        .o_state (st0)
    );

    popcount_stream #(.DATA_W(DATA_W), .CHUNK_W(1024)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .bus     (u_bus1),
        .o_state (st1)
    );

    int n_checks = 0;
    int n_err    = 0;
    logic [CNT_W-1:0] exp_q[$];

    typedef struct {
        string             name;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  thr;
        int                exp_cnt;
        int                exp_ge;
        int                hold;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random vector with varied bit density, from empty to full.
    function automatic logic [DATA_W-1:0] rand_vec();
        logic [DATA_W-1:0] v;
        int mode;
        mode = $urandom_range(0, 5);
        for (int w = 0; w < DATA_W / 32; w++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] c;
            a = $urandom;
            b = $urandom;
            c = $urandom;
            case (mode)
                0:       v[w*32 +: 32] = a;
                1:       v[w*32 +: 32] = a & b;
                2:       v[w*32 +: 32] = a | b;
                3:       v[w*32 +: 32] = a & b & c;
                4:       v[w*32 +: 32] = '1;
                default: v[w*32 +: 32] = (w == 0 || w == DATA_W / 32 - 1) ? a : 32'h0;
            endcase
        end
        return v;
    endfunction

    task automatic accept(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] th);
        int guard;
        guard = 0;
        while (!u_bus0.in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        thresh   = th;
        step();
        in_valid = 1'b0;
    endtask

    // One full transaction: accept, scramble inputs during RUN, check both
    // results and latencies, hold backpressure, then release.
    task automatic do_vec(input string name, input logic [DATA_W-1:0] d,
                          input logic [CNT_W-1:0] th, input int hold,
                          input int exp_cnt, input int exp_ge);
        int lat0;
        int lat1;
        accept(d, th);
        chk({name, "_run_in_ready"}, int'(u_bus0.in_ready), 0);
        chk({name, "_run_count"}, int'(u_bus0.out_count), 0);
        chk({name, "_run_ge"}, int'(u_bus0.out_ge), 0);
        lat0 = 0;
        lat1 = -1;
        while (!u_bus0.out_valid && lat0 < 100) begin
            if (u_bus1.out_valid && lat1 < 0) lat1 = lat0;
            in_data  = rand_vec();
            in_valid = 1'($urandom_range(0, 1));
            thresh   = CNT_W'($urandom);
            step();
            lat0++;
        end
        in_valid = 1'b0;
        chk({name, "_latency64"}, lat0, 16);
        chk({name, "_latency1024"}, lat1, 1);
        chk({name, "_count64"}, int'(u_bus0.out_count), exp_cnt);
        chk({name, "_ge64"}, int'(u_bus0.out_ge), exp_ge);
        chk({name, "_count1024"}, int'(u_bus1.out_count), exp_cnt);
        chk({name, "_ge1024"}, int'(u_bus1.out_ge), exp_ge);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({name, "_hold_valid"}, int'(u_bus0.out_valid), 1);
            chk({name, "_hold_count"}, int'(u_bus0.out_count), exp_cnt);
            chk({name, "_hold_ge"}, int'(u_bus0.out_ge), exp_ge);
            chk({name, "_hold_in_ready"}, int'(u_bus0.in_ready), 0);
        end
        // in_valid=1 on the release edge must not be taken as an accept.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({name, "_rel_state64"}, int'(st0), int'(ST_IDLE));
        chk({name, "_rel_state1024"}, int'(st1), int'(ST_IDLE));
        chk({name, "_rel_valid"}, int'(u_bus0.out_valid), 0);
        chk({name, "_rel_count"}, int'(u_bus0.out_count), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_state64"}, int'(st0), int'(ST_IDLE));
        chk({name, "_state1024"}, int'(st1), int'(ST_IDLE));
        chk({name, "_in_ready"}, int'(u_bus0.in_ready), 1);
        chk({name, "_out_valid"}, int'(u_bus0.out_valid), 0);
        chk({name, "_out_count"}, int'(u_bus0.out_count), 0);
        chk({name, "_out_ge"}, int'(u_bus0.out_ge), 0);
        chk({name, "_out_valid1024"}, int'(u_bus1.out_valid), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic [CNT_W-1:0]  th;
        logic [CNT_W-1:0]  e;
        int                guard;

        // Clock/reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        thresh    = '0;
        step();
        step();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Directed table
        tbl[0] = '{"zeros", '0, 11'd0, 0, 1, 0};
        tbl[1] = '{"ones", '1, 11'd1025, 1024, 0, 0};
        d = '0;
        d[0] = 1'b1;
        d[DATA_W-1] = 1'b1;
        tbl[2] = '{"first_last", d, 11'd2, 2, 1, 0};
        tbl[3] = '{"alt_aa", {32{32'hAAAA_AAAA}}, 11'd513, 512, 0, 0};
        d = '0;
        d[DATA_W/2-1:0] = '1;
        tbl[4] = '{"low_half", d, 11'd512, 512, 1, 0};
        tbl[5] = '{"backpressure", {32{32'h0000_0101}}, 11'd64, 64, 1, 5};
        for (int i = 0; i < 6; i++) begin
            do_vec(tbl[i].name, tbl[i].data, tbl[i].thr, tbl[i].hold,
                   tbl[i].exp_cnt, tbl[i].exp_ge);
        end

        // Reset at the 8th RUN cycle discards the vector.
        accept('1, 11'd0);
        for (int i = 0; i < 7; i++) step();
        chk("mid_run_state", int'(st0), int'(ST_RUN));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("mid_run_rst");
        d = '0;
        d[DATA_W/2-1:0] = '1;
        do_vec("after_rst", d, 11'd0, 0, 512, 1);

        // Reset in DONE wins over out_ready and in_valid on the same edge.
        accept('1, 11'd0);
        guard = 0;
        while (!u_bus0.out_valid && guard < 100) begin
            step();
            guard++;
        end
        chk("done_reach", int'(u_bus0.out_valid), 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        chk_reset_outputs("done_rst");
        // Still in reset with in_valid=1: no accept may happen.
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk_reset_outputs("idle_rst_accept");

        // Random back-to-back vectors against the reference count.
        for (int i = 0; i < 200; i++) begin
            d  = rand_vec();
            th = CNT_W'($urandom_range(0, 1100));
            exp_q.push_back(CNT_W'($countones(d)));
            e = exp_q.pop_front();
            do_vec("rand", d, th, $urandom_range(0, 3), int'(e),
                   (int'(e) >= int'(th)) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
